rr_token_arbiter: RTL and testbench

Centralised round-robin arbiter that shares one resource among N clients. Each client uses a 4-phase req/ack handshake. The block keeps a rotating priority pointer (the token) and guarantees that at most one ack is high. It bounds how long a client can hold the resource by asserting a revoke request once a hold limit is reached. It replaces the distributed per-client token-passing controllers plus selector in the client/resource subsystem.

---
 rtl/rr_token_arbiter_if.sv | 16 +
 rtl/rr_token_arbiter.sv | 105 ++++++++++
 tb/tb_rr_token_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rr_token_arbiter_if.sv
// Client-side bundle for the round-robin token arbiter.
// The master modport is the client view and the slave modport is the arbiter view.
interface rr_token_arbiter_if #(
  parameter int N   = 3,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   ack;
  logic [N-1:0]   revoke;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           abort;

  modport master (output req, input ack, revoke, grant_id, busy, abort);
  modport slave  (input req, output ack, revoke, grant_id, busy, abort);
endinterface

// File: rtl/rr_token_arbiter.sv
// Centralised round-robin arbiter: one resource shared by N req/ack clients,
// with a rotating priority pointer and an optional hold-limit revoke request.
module rr_token_arbiter #(
  parameter int N        = 3,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input logic               clk,
  input logic               rst,
  rr_token_arbiter_if.slave bus
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HC_LIM = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, BUSY} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant_id;
  logic [N-1:0]   r_ack;
  logic [N-1:0]   r_revoke;
  logic [HW-1:0]  r_hold_cnt;
  logic           r_abort;

  logic           w_found;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_next_ptr;
  logic           w_req_sel;

  // Scan downwards so the match closest to r_ptr is written last and wins.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_sel   = '0;
    j       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      if (bus.req[j]) begin
        w_found = 1'b1;
        w_sel   = IDW'(j);
      end
    end
  end

  assign w_next_ptr = (r_grant_id == IDW'(N - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_req_sel  = bus.req[r_grant_id];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_ack      <= '0;
      r_revoke   <= '0;
      r_hold_cnt <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id <= w_sel;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          if (w_req_sel) begin
            r_ack      <= N'(1) << r_grant_id;
            r_hold_cnt <= '0;
            r_state    <= BUSY;
          end else begin
            r_abort <= 1'b1;
            r_ptr   <= w_next_ptr;
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (w_req_sel) begin
            // Revoke is only a request; ack stays until the client lets go.
            if (MAX_HOLD != 0 && r_hold_cnt == HC_LIM) begin
              r_revoke <= N'(1) << r_grant_id;
            end else if (r_hold_cnt != '1) begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end else begin
            r_ack    <= '0;
            r_revoke <= '0;
            r_ptr    <= w_next_ptr;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.revoke   = r_revoke;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = (r_state != IDLE);
  assign bus.abort    = r_abort;

endmodule

// File: tb/tb_rr_token_arbiter.sv
// Directed bench for rr_token_arbiter: one instance with MAX_HOLD=4 for the
// main scenarios and one with MAX_HOLD=0 to show revoke disabled.
module tb_rr_token_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  rr_token_arbiter_if #(.N(3), .IDW(2)) if_a ();
  rr_token_arbiter_if #(.N(3), .IDW(2)) if_z ();

  rr_token_arbiter #(.N(3), .IDW(2), .MAX_HOLD(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  rr_token_arbiter #(.N(3), .IDW(2), .MAX_HOLD(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if_z.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_a.req = 3'b000;
    if_z.req = 3'b000;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    n_vec++; if (if_a.ack !== 3'b000)     begin n_err++; $display("FAIL reset_ack got=%b exp=000", if_a.ack); end
    n_vec++; if (if_a.revoke !== 3'b000)  begin n_err++; $display("FAIL reset_revoke got=%b exp=000", if_a.revoke); end
    n_vec++; if (if_a.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", if_a.busy); end
    n_vec++; if (if_a.grant_id !== 2'd0)  begin n_err++; $display("FAIL reset_grant_id got=%0d exp=0", if_a.grant_id); end
    n_vec++; if (if_a.abort !== 1'b0)     begin n_err++; $display("FAIL reset_abort got=%b exp=0", if_a.abort); end
  endtask

  task automatic test_async_reset();
    if_a.req = 3'b100;
    tick(); tick();
    n_vec++; if (if_a.ack !== 3'b100) begin n_err++; $display("FAIL async_pre_ack got=%b exp=100", if_a.ack); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (if_a.ack !== 3'b000) begin n_err++; $display("FAIL async_rst_ack got=%b exp=000", if_a.ack); end
    n_vec++; if (if_a.busy !== 1'b0)  begin n_err++; $display("FAIL async_rst_busy got=%b exp=0", if_a.busy); end
    if_a.req = 3'b000;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    if_a.req = 3'b010;
    tick();
    n_vec++; if (if_a.busy !== 1'b1)  begin n_err++; $display("FAIL single_busy_e0 got=%b exp=1", if_a.busy); end
    n_vec++; if (if_a.ack !== 3'b000) begin n_err++; $display("FAIL single_ack_e0 got=%b exp=000", if_a.ack); end
    tick();
    n_vec++; if (if_a.ack !== 3'b010)    begin n_err++; $display("FAIL single_ack_e1 got=%b exp=010", if_a.ack); end
    n_vec++; if (if_a.grant_id !== 2'd1) begin n_err++; $display("FAIL single_gid got=%0d exp=1", if_a.grant_id); end
    tick(); tick(); tick();
    n_vec++; if (if_a.ack !== 3'b010) begin n_err++; $display("FAIL single_ack_e4 got=%b exp=010", if_a.ack); end
    if_a.req = 3'b000;
    tick();
    n_vec++; if (if_a.ack !== 3'b000)     begin n_err++; $display("FAIL single_ack_drop got=%b exp=000", if_a.ack); end
    n_vec++; if (if_a.busy !== 1'b0)      begin n_err++; $display("FAIL single_busy_drop got=%b exp=0", if_a.busy); end
    n_vec++; if (u_dut.r_ptr !== 2'd2)    begin n_err++; $display("FAIL single_ptr got=%0d exp=2", u_dut.r_ptr); end
  endtask

  task automatic test_wrap();
    if_a.req = 3'b011;
    tick();
    n_vec++; if (if_a.grant_id !== 2'd0) begin n_err++; $display("FAIL wrap_gid0 got=%0d exp=0", if_a.grant_id); end
    tick();
    n_vec++; if (if_a.ack !== 3'b001) begin n_err++; $display("FAIL wrap_ack0 got=%b exp=001", if_a.ack); end
    if_a.req = 3'b010;
    tick();
    n_vec++; if (if_a.ack !== 3'b000)  begin n_err++; $display("FAIL wrap_rel0 got=%b exp=000", if_a.ack); end
    n_vec++; if (u_dut.r_ptr !== 2'd1) begin n_err++; $display("FAIL wrap_ptr1 got=%0d exp=1", u_dut.r_ptr); end
    tick();
    n_vec++; if (if_a.grant_id !== 2'd1) begin n_err++; $display("FAIL wrap_gid1 got=%0d exp=1", if_a.grant_id); end
    tick();
    n_vec++; if (if_a.ack !== 3'b010) begin n_err++; $display("FAIL wrap_ack1 got=%b exp=010", if_a.ack); end
    if_a.req = 3'b000;
    tick();
    n_vec++; if (u_dut.r_ptr !== 2'd2) begin n_err++; $display("FAIL wrap_ptr2 got=%0d exp=2", u_dut.r_ptr); end
  endtask

  task automatic test_contention();
    int exp_order[5] = '{0, 1, 2, 0, 1};
    logic [2:0] exp_ack;
    int waited;
    int k;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_a.req = 3'b111;
    for (int g = 0; g < 5; g++) begin
      k = exp_order[g];
      exp_ack = 3'b001 << k;
      waited = 0;
      while (if_a.ack === 3'b000 && waited < 20) begin
        tick();
        waited++;
      end
      n_vec++; if (if_a.ack !== exp_ack) begin n_err++; $display("FAIL contention_grant%0d got=%b exp=%b", g, if_a.ack, exp_ack); end
      tick();
      n_vec++; if (!$onehot0(if_a.ack)) begin n_err++; $display("FAIL contention_onehot%0d got=%b exp=onehot0", g, if_a.ack); end
      tick();
      if_a.req[k] = 1'b0;
      tick();
      n_vec++; if (if_a.ack !== 3'b000) begin n_err++; $display("FAIL contention_gap%0d got=%b exp=000", g, if_a.ack); end
      if_a.req[k] = 1'b1;
    end
    if_a.req = 3'b000;
    repeat (4) tick();
  endtask

  task automatic test_revoke();
    if_a.req = 3'b100;
    tick();
    tick();
    n_vec++; if (if_a.ack !== 3'b100) begin n_err++; $display("FAIL revoke_ack got=%b exp=100", if_a.ack); end
    tick(); tick(); tick();
    n_vec++; if (if_a.revoke !== 3'b000) begin n_err++; $display("FAIL revoke_early got=%b exp=000", if_a.revoke); end
    tick();
    n_vec++; if (if_a.revoke !== 3'b100) begin n_err++; $display("FAIL revoke_set got=%b exp=100", if_a.revoke); end
    repeat (3) tick();
    n_vec++; if (if_a.revoke !== 3'b100) begin n_err++; $display("FAIL revoke_held got=%b exp=100", if_a.revoke); end
    n_vec++; if (if_a.ack !== 3'b100)    begin n_err++; $display("FAIL revoke_ack_held got=%b exp=100", if_a.ack); end
    if_a.req = 3'b000;
    tick();
    n_vec++; if (if_a.ack !== 3'b000)    begin n_err++; $display("FAIL revoke_rel_ack got=%b exp=000", if_a.ack); end
    n_vec++; if (if_a.revoke !== 3'b000) begin n_err++; $display("FAIL revoke_rel_rev got=%b exp=000", if_a.revoke); end
    tick();
  endtask

  task automatic test_no_revoke();
    int bad;
    bad = 0;
    if_z.req = 3'b001;
    tick(); tick();
    n_vec++; if (if_z.ack !== 3'b001) begin n_err++; $display("FAIL norev_ack got=%b exp=001", if_z.ack); end
    for (int c = 0; c < 50; c++) begin
      tick();
      if (if_z.revoke !== 3'b000 || if_z.ack !== 3'b001) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL norev_hold bad_cycles=%0d exp=0", bad); end
    if_z.req = 3'b000;
    tick();
    n_vec++; if (if_z.ack !== 3'b000) begin n_err++; $display("FAIL norev_rel got=%b exp=000", if_z.ack); end
  endtask

  task automatic test_abort();
    if_a.req = 3'b001;
    tick();
    n_vec++; if (if_a.grant_id !== 2'd0) begin n_err++; $display("FAIL abort_gid got=%0d exp=0", if_a.grant_id); end
    if_a.req = 3'b000;
    tick();
    n_vec++; if (if_a.abort !== 1'b1)  begin n_err++; $display("FAIL abort_pulse got=%b exp=1", if_a.abort); end
    n_vec++; if (if_a.ack !== 3'b000)  begin n_err++; $display("FAIL abort_ack got=%b exp=000", if_a.ack); end
    n_vec++; if (if_a.busy !== 1'b0)   begin n_err++; $display("FAIL abort_busy got=%b exp=0", if_a.busy); end
    n_vec++; if (u_dut.r_ptr !== 2'd1) begin n_err++; $display("FAIL abort_ptr got=%0d exp=1", u_dut.r_ptr); end
    tick();
    n_vec++; if (if_a.abort !== 1'b0)  begin n_err++; $display("FAIL abort_clear got=%b exp=0", if_a.abort); end
  endtask

  initial begin
    if_a.req = 3'b000;
    if_z.req = 3'b000;
    test_reset();
    test_async_reset();
    test_single();
    test_wrap();
    test_contention();
    test_revoke();
    test_no_revoke();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
